// File: rtl/ctrl_seq_pkg.sv
// Shared widths, instruction layout and FSM state encoding for the ctrl_seq sequencer.
package ctrl_seq_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int BUS_WIDTH    = 8;
    localparam int OPCODE_WIDTH = 6;
    localparam int REG_AW       = 4;
    localparam int PC_WIDTH     = 8;
    localparam int INSTR_W      = OPCODE_WIDTH + REG_AW + 2 * BUS_WIDTH;

    localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        SFETCH  = 3'd0,
        SDECODE = 3'd1,
        SREAD   = 3'd2,
        SCALC   = 3'd3,
        SWRITE  = 3'd4,
        SHALT   = 3'd5
    } state_t;

endpackage

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, operand read, ALU handshake, writeback.
// The ALU and register file sit beside this block at the top level.
module ctrl_seq #(
    parameter int DATA_WIDTH   = ctrl_seq_pkg::DATA_WIDTH,
    parameter int BUS_WIDTH    = ctrl_seq_pkg::BUS_WIDTH,
    parameter int OPCODE_WIDTH = ctrl_seq_pkg::OPCODE_WIDTH,
    parameter int REG_AW       = ctrl_seq_pkg::REG_AW,
    parameter int PC_WIDTH     = ctrl_seq_pkg::PC_WIDTH,
    localparam int INSTR_W     = OPCODE_WIDTH + REG_AW + 2 * BUS_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [PC_WIDTH-1:0]     pc,
    input  logic [INSTR_W-1:0]      instr,
    input  logic                    instr_valid,
    output logic [REG_AW-1:0]       rd_addr1,
    output logic [REG_AW-1:0]       rd_addr2,
    input  logic [DATA_WIDTH-1:0]   rd_data1,
    input  logic [DATA_WIDTH-1:0]   rd_data2,
    output logic                    alu_en,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0]   value1,
    output logic [DATA_WIDTH-1:0]   value2,
    output logic [BUS_WIDTH-1:0]    addr1,
    output logic [BUS_WIDTH-1:0]    addr2,
    input  logic [DATA_WIDTH-1:0]   result,
    input  logic                    calc_done,
    input  logic                    err,
    input  logic                    finish,
    output logic                    wr_en,
    output logic [REG_AW-1:0]       wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    halted,
    output logic                    fault,
    output logic [15:0]             retired
);
    import ctrl_seq_pkg::*;

    localparam int A2_LSB  = 0;
    localparam int A1_LSB  = BUS_WIDTH;
    localparam int DST_LSB = 2 * BUS_WIDTH;
    localparam int OP_LSB  = 2 * BUS_WIDTH + REG_AW;

    state_t                  state_q, state_d;
    logic [INSTR_W-1:0]      ir_q, ir_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   value1_q, value1_d;
    logic [DATA_WIDTH-1:0]   value2_q, value2_d;
    logic                    wr_en_q, wr_en_d;
    logic [REG_AW-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [15:0]             retired_q, retired_d;
    logic                    fault_q, fault_d;
    logic [REG_AW-1:0]       ir_dst;

    // Operand fields come straight from the instruction register, so they
    // stay valid from decode through writeback and hold until the next fetch.
    assign ir_dst   = ir_q[DST_LSB +: REG_AW];
    assign rd_addr1 = ir_q[A1_LSB +: REG_AW];
    assign rd_addr2 = ir_q[A2_LSB +: REG_AW];
    assign opcode   = ir_q[OP_LSB +: OPCODE_WIDTH];
    assign addr1    = ir_q[A1_LSB +: BUS_WIDTH];
    assign addr2    = ir_q[A2_LSB +: BUS_WIDTH];

    assign pc      = pc_q;
    assign value1  = value1_q;
    assign value2  = value2_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign retired = retired_q;
    assign fault   = fault_q;
    assign halted  = (state_q == SHALT);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        value1_d  = value1_q;
        value2_d  = value2_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        alu_en    = 1'b0;
        case (state_q)
            SFETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = SDECODE;
                end
            end
            SDECODE: state_d = SREAD;
            SREAD: begin
                value1_d = rd_data1;
                value2_d = rd_data2;
                state_d  = SCALC;
            end
            SCALC: begin
                // finish outranks err, so a simultaneous pair halts cleanly
                if (finish) begin
                    state_d = SHALT;
                end else if (err) begin
                    state_d = SHALT;
                    fault_d = 1'b1;
                end else begin
                    alu_en = 1'b1;
                    if (calc_done) state_d = SWRITE;
                end
            end
            SWRITE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ir_dst;
                wr_data_d = result;
                pc_d      = pc_q + PC_WIDTH'(1);
                if (retired_q != RETIRED_MAX) retired_d = retired_q + 16'd1;
                state_d   = SFETCH;
            end
            SHALT: state_d = SHALT;
            default: state_d = SFETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SFETCH;
            ir_q      <= '0;
            pc_q      <= '0;
            value1_q  <= '0;
            value2_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            value1_q  <= value1_d;
            value2_q  <= value2_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq with a behavioural ALU, register file and reference model.
module tb_ctrl_seq;
    import ctrl_seq_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [PC_WIDTH-1:0]     pc;
    logic [INSTR_W-1:0]      instr = '0;
    logic                    instr_valid = 1'b0;
    logic [REG_AW-1:0]       rd_addr1, rd_addr2;
    logic [DATA_WIDTH-1:0]   rd_data1, rd_data2;
    logic                    alu_en;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0]   value1, value2;
    logic [BUS_WIDTH-1:0]    addr1, addr2;
    logic [DATA_WIDTH-1:0]   result = '0;
    logic                    calc_done, err, finish;
    logic                    wr_en;
    logic [REG_AW-1:0]       wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    halted, fault;
    logic [15:0]             retired;

    int checks = 0;
    int errors = 0;

    ctrl_seq dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .alu_en(alu_en), .opcode(opcode), .value1(value1), .value2(value2),
        .addr1(addr1), .addr2(addr2), .result(result), .calc_done(calc_done),
        .err(err), .finish(finish), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    // Environment: register file with a preload port, and a simple ALU with
    // programmable latency. 6'h3F = finish, 6'h3E = err, 6'h3D = both.
    logic [DATA_WIDTH-1:0] regs [16];
    logic                  pre_we = 1'b0;
    logic [3:0]            pre_addr = '0;
    logic [7:0]            pre_data = '0;
    int                    alu_lat = 0;
    int                    alu_cnt = 0;
    int                    wr_cnt = 0;
    int                    overlap_cnt = 0;

    assign rd_data1  = regs[rd_addr1];
    assign rd_data2  = regs[rd_addr2];
    assign calc_done = alu_en && (alu_cnt == alu_lat);
    assign finish    = (opcode == 6'h3F) || (opcode == 6'h3D);
    assign err       = (opcode == 6'h3E) || (opcode == 6'h3D);

    function automatic logic [7:0] alu_func(input logic [5:0] op, input logic [7:0] v1, v2, a1, a2);
        case (op)
            6'd0: return v1 + v2;
            6'd1: return v1 - v2;
            6'd2: return v1 ^ v2;
            6'd3: return a1 + a2;
            6'd4: return v1 & v2;
            default: return v1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (pre_we) regs[pre_addr] <= pre_data;
        else if (wr_en) regs[wr_addr] <= wr_data;
        if (alu_en && !calc_done) alu_cnt <= alu_cnt + 1;
        else alu_cnt <= 0;
        if (alu_en && calc_done) result <= alu_func(opcode, value1, value2, addr1, addr2);
        if (wr_en) wr_cnt <= wr_cnt + 1;
    end

    always @(negedge clk) if (alu_en && wr_en) overlap_cnt <= overlap_cnt + 1;

    // Reference model state: architectural registers, pc and retire count.
    logic [7:0] mregs [16];
    logic [7:0] mpc = '0;
    int         mret = 0;
    int         exp_wr_cnt = 0;

    function automatic logic [7:0] ref_result(input logic [5:0] op, input logic [7:0] a1, a2);
        int x, y, r;
        x = int'(mregs[a1[3:0]]);
        y = int'(mregs[a2[3:0]]);
        case (op)
            6'd0: r = x + y;
            6'd1: r = x - y + 256;
            6'd2: r = x ^ y;
            6'd3: r = int'(a1) + int'(a2);
            6'd4: r = x & y;
            default: r = x;
        endcase
        return 8'(r % 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit preload);
        rst = 1'b1;
        @(negedge clk);
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                pre_we = 1'b1; pre_addr = 4'(i);
                pre_data = (i == 1) ? 8'h05 : (i == 2) ? 8'h07 : 8'($urandom);
                mregs[i] = pre_data;
                @(negedge clk);
            end
            pre_we = 1'b0;
        end
        @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_retired", retired, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_alu_en", alu_en, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_opcode_addr", {opcode, addr1, addr2}, 0);
        check("rst_values", {value1, value2}, 0);
        check("rst_wr_fields", {wr_addr, wr_data}, 0);
        mpc = '0;
        mret = 0;
        rst = 1'b0;
    endtask

    // mode 0: expect writeback; 1: expect clean halt; 2: expect halt with fault
    task automatic run_instr(input logic [5:0] op, input logic [3:0] dst, input logic [7:0] a1, a2,
                             input int lat, input int wait_c, input int mode);
        int n;
        bit got;
        int start_wr;
        logic [7:0] exp;
        alu_lat = lat;
        repeat (wait_c) @(negedge clk);
        check("pc_at_fetch", pc, mpc);
        exp = ref_result(op, a1, a2);
        start_wr = wr_cnt;
        instr = {op, dst, a1, a2};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 1;
        got = 0;
        while (!got && n < 40) begin
            if (wr_en === 1'b1 || halted === 1'b1) got = 1;
            else begin
                instr_valid = 1'($urandom_range(0, 1));
                instr = INSTR_W'($urandom);
                @(negedge clk);
                n++;
            end
        end
        instr_valid = 1'b0;
        check("no_timeout", 32'(got), 1);
        if (mode == 0) begin
            mregs[dst] = exp;
            mpc = mpc + 8'd1;
            mret++;
            exp_wr_cnt++;
            check("wr_en", wr_en, 1);
            check("latency", n, 5 + lat);
            check("wr_addr", wr_addr, dst);
            check("wr_data", wr_data, exp);
            check("no_early_wr", wr_cnt - start_wr, 0);
            check("pc_after", pc, mpc);
            check("retired", retired, mret);
            @(negedge clk);
            check("wr_en_one_cycle", wr_en, 0);
        end else begin
            check("halted", halted, 1);
            check("halt_latency", n, 4);
            check("halt_fault", fault, 32'(mode == 2));
            check("halt_no_wr", wr_en, 0);
            for (int i = 0; i < 8; i++) begin
                instr_valid = 1'b1;
                instr = {6'd0, 4'(i), 8'h01, 8'h02};
                @(negedge clk);
                check("halt_alu_en", alu_en, 0);
            end
            instr_valid = 1'b0;
            check("halt_sticky", halted, 1);
            check("halt_pc_frozen", pc, mpc);
            check("halt_no_wr_total", wr_cnt - start_wr, 0);
            check("halt_fault_stable", fault, 32'(mode == 2));
        end
    endtask

    initial begin
        do_reset(1'b1);

        run_instr(6'd0, 4'd3, 8'h01, 8'h02, 0, 0, 0);
        check("r3_sum", regs[3], 8'h0C);
        run_instr(6'd3, 4'd9, 8'h10, 8'h20, 0, 0, 0);
        check("imm_sum", regs[9], 8'h30);

        while (mpc != 8'hFF) begin
            run_instr(6'($urandom_range(0, 4)), 4'($urandom), 8'($urandom), 8'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 2), 0);
        end
        run_instr(6'd1, 4'd5, 8'hA3, 8'h77, 1, 1, 0);
        check("pc_wrap", pc, 8'h00);

        run_instr(6'h3E, 4'd6, 8'h01, 8'h02, 0, 0, 2);
        do_reset(1'b0);
        run_instr(6'h3D, 4'd6, 8'h01, 8'h02, 0, 0, 1);
        do_reset(1'b0);
        run_instr(6'h3F, 4'd6, 8'h01, 8'h02, 0, 0, 1);
        do_reset(1'b0);

        begin : rst_mid_calc
            int start_wr;
            run_instr(6'd2, 4'd7, 8'h03, 8'h04, 0, 0, 0);
            start_wr = wr_cnt;
            alu_lat = 6;
            instr = {6'd0, 4'd8, 8'h01, 8'h02};
            instr_valid = 1'b1;
            @(negedge clk);
            instr_valid = 1'b0;
            repeat (2) @(negedge clk);
            check("scalc_alu_en", alu_en, 1);
            #2 rst = 1'b1;
            #1 check("rst_async_alu_en", alu_en, 0);
            repeat (2) @(negedge clk);
            check("abort_pc", pc, 0);
            check("abort_retired", retired, 0);
            rst = 1'b0;
            mpc = '0;
            mret = 0;
            repeat (4) @(negedge clk);
            check("abort_no_wr", wr_cnt - start_wr, 0);
            run_instr(6'd0, 4'd8, 8'h01, 8'h02, 0, 0, 0);
        end

        @(negedge clk);
        check("total_wr_pulses", wr_cnt, exp_wr_cnt);
        check("no_alu_wr_overlap", overlap_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
